framebuffer_writer: RTL and testbench
=====================================

# framebuffer_writer

Byte-stream command decoder that turns received UART bytes into framebuffer write cycles. It sits between the UART receiver, upstream, and port A of the dual-port `framebuffer`. Port A is the control side: 8-bit data, 12-bit byte address, 4096 bytes, which holds one 64x32 RGB565 frame. It supports full-frame loads and single-byte pokes, and drives the port A clock-enable and write strobes directly.

## Interface
Parameters:
- `TIMEOUT_WIDTH`, default 16: width of the inter-byte timeout counter.
- `TIMEOUT_CYCLES`, default 16'd65535: number of idle clk_in cycles allowed between bytes of one command (about 1.2 ms at 53.2 MHz).

Ports:
- `clk_in`  in  1: single clock. It also drives framebuffer `ClockA`.
- `reset`  in  1: asynchronous, active-low reset (0 = reset).
- `rx_data`  in  8: received byte. Valid only while `rx_strobe` is 1.
- `rx_strobe`  in  1: one-cycle pulse per received byte. May be asserted on consecutive cycles.
- `ram_data_out`  out  8: to `DataInA`.
- `ram_address`  out  12: to `AddressA`.
- `ram_clk_enable`  out  1: to `ClockEnA`.
- `ram_write_enable`  out  1: to `WrA`.
- `busy`  out  1: high while any command is in progress, i.e. state is not IDLE.
- `frame_done`  out  1: one-cycle pulse after the 4096th byte of a frame load.
- `error`  out  1: one-cycle pulse on a protocol error or a timeout.

## Operation
State machine with five states: IDLE, LOAD, ADDR_HI, ADDR_LO, DATA. Only a cycle with `rx_strobe`=1 advances a state, except for the timeout.

IDLE:
- 0x4C ('L') -> LOAD. Byte counter is cleared to 0.
- 0x50 ('P') -> ADDR_HI.
- Any other byte -> `error` pulse; remain in IDLE.

LOAD:
- Each byte is written to address = byte counter, then the counter increments.
- The byte written at address 4095 -> `frame_done` pulse and return to IDLE. The counter does not wrap inside a frame.

ADDR_HI:
- `rx_data[7:4]` must be 0. If so, `rx_data[3:0]` is latched as address[11:8] and the state moves to ADDR_LO.
- Otherwise -> `error` pulse, return to IDLE, no write.

ADDR_LO:
- `rx_data` is latched as address[7:0]; move to DATA.

DATA:
- The byte is written to the latched address; return to IDLE.

Write cycle:
- `ram_clk_enable` and `ram_write_enable` are both 1 for exactly one cycle.
- During that cycle `ram_address` and `ram_data_out` are valid.
- At all other times both strobes are 0. `ram_address` and `ram_data_out` hold their last values.

Reset:
- Reset asserted at any time forces IDLE, clears the counter and the timeout, and drives all outputs to 0.
- An in-progress write is dropped.

## Timing
- Write latency: a byte strobed in cycle N produces its write strobes in cycle N+1 (registered outputs).
- Back-to-back strobes on consecutive cycles produce writes on consecutive cycles. No byte is lost.
- `frame_done` is asserted in the same cycle as the final (address 4095) write strobe.
- `error` for a bad byte is asserted in cycle N+1.
- `busy` updates in cycle N+1.
- Timeout counter:
  - Reloads to `TIMEOUT_CYCLES` on every strobe and on entry to any non-IDLE state.
  - Decrements each cycle while not in IDLE.
  - On reaching 0: `error` pulse, return to IDLE, no write.
  - A strobe in the same cycle the counter reaches 0 wins: the byte is processed and the counter reloads.
- No flow control: `rx_strobe` is never stalled or back-pressured.

## Configuration
- `FB_WRITER_TIMEOUT_EN` defined: the inter-byte timeout is compiled in, as described under Timing.
- `FB_WRITER_TIMEOUT_EN` undefined:
  - No counter is built; the timeout parameters are unused.
  - A partially received command waits indefinitely.
  - Recovery is only by completing the command or by reset.

## Test plan
- Reset values: hold `reset`=0, then release. All outputs are 0 and `busy`=0. A strobe of 0x4C raises `busy` the next cycle.
- Full frame load: send 0x4C, then 4096 bytes with values (i & 0xFF) on back-to-back strobes. Expect:
  - 4096 writes with addresses 0..4095 and data matching.
  - A single `frame_done` pulse coincident with the address 4095 write.
  - Return to IDLE.
- Single poke: send 0x50, 0x01, 0x23, 0xAB. Expect exactly one write, address 0x123, data 0xAB, one cycle after the 0xAB strobe.
- Protocol errors:
  - Send 0x00 in IDLE -> `error` pulse, no write.
  - Send 0x50, 0x10 -> `error` pulse, back to IDLE; a following 0x4C is accepted as a command.
- Timeout (macro defined, `TIMEOUT_CYCLES`=100):
  - Send 0x4C plus 3 bytes, then idle. Expect an `error` pulse about 100 cycles after the last strobe, then IDLE.
  - A new 0x4C load then writes starting at address 0.
- Reset mid-load: assert `reset` after 10 bytes of a load. Expect no further writes, IDLE after release, and a new load starting at address 0.

Source files
------------

// File: rtl/framebuffer_writer.sv
// UART byte-stream decoder driving framebuffer port A: 'L' frame loads and 'P' single-byte pokes.
// Optional inter-byte timeout compiled in with `define FB_WRITER_TIMEOUT_EN.
module framebuffer_writer #(
  parameter int unsigned TIMEOUT_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16'd65535
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_strobe,
  output logic [7:0]  ram_data_out,
  output logic [11:0] ram_address,
  output logic        ram_clk_enable,
  output logic        ram_write_enable,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  CMD_POKE  = 8'h50;
  localparam logic [11:0] LAST_ADDR = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_DATA
  } state_t;

  state_t      state;
  logic [11:0] byte_cnt;
  logic [3:0]  addr_hi;
  logic [7:0]  addr_lo;

  if (TIMEOUT_WIDTH == 0 || TIMEOUT_WIDTH > 32 ||
      (TIMEOUT_WIDTH < 32 && (TIMEOUT_CYCLES >> TIMEOUT_WIDTH) != 0)) begin : g_bad_timeout_cfg
    $error("framebuffer_writer: TIMEOUT_CYCLES does not fit in TIMEOUT_WIDTH");
  end

`ifdef FB_WRITER_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_RELOAD = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
`endif

  // busy decodes the state register directly, so it follows the strobe by one cycle
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      byte_cnt         <= '0;
      addr_hi          <= '0;
      addr_lo          <= '0;
      ram_data_out     <= '0;
      ram_address      <= '0;
      ram_clk_enable   <= 1'b0;
      ram_write_enable <= 1'b0;
      frame_done       <= 1'b0;
      error            <= 1'b0;
`ifdef FB_WRITER_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      ram_clk_enable   <= 1'b0;
      ram_write_enable <= 1'b0;
      frame_done       <= 1'b0;
      error            <= 1'b0;
      if (rx_strobe) begin
`ifdef FB_WRITER_TIMEOUT_EN
        tmo_cnt <= TMO_RELOAD;
`endif
        case (state)
          S_IDLE: begin
            if (rx_data == CMD_LOAD) begin
              state    <= S_LOAD;
              byte_cnt <= '0;
            end else if (rx_data == CMD_POKE) begin
              state <= S_ADDR_HI;
            end else begin
              error <= 1'b1;
            end
          end
          S_LOAD: begin
            ram_clk_enable   <= 1'b1;
            ram_write_enable <= 1'b1;
            ram_address      <= byte_cnt;
            ram_data_out     <= rx_data;
            byte_cnt         <= byte_cnt + 12'd1;
            if (byte_cnt == LAST_ADDR) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end
          end
          S_ADDR_HI: begin
            // Only 4 address bits exist above bit 7; a nonzero upper nibble is a framing error
            if (rx_data[7:4] == 4'h0) begin
              addr_hi <= rx_data[3:0];
              state   <= S_ADDR_LO;
            end else begin
              error <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_ADDR_LO: begin
            addr_lo <= rx_data;
            state   <= S_DATA;
          end
          S_DATA: begin
            ram_clk_enable   <= 1'b1;
            ram_write_enable <= 1'b1;
            ram_address      <= {addr_hi, addr_lo};
            ram_data_out     <= rx_data;
            state            <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
`ifdef FB_WRITER_TIMEOUT_EN
      // A strobe on the expiry cycle takes the branch above, so the byte wins over the timeout
      else if (state != S_IDLE) begin
        if (tmo_cnt == '0) begin
          error <= 1'b1;
          state <= S_IDLE;
        end else begin
          tmo_cnt <= tmo_cnt - 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Randomized bench for framebuffer_writer with a command-level reference model of expected writes.
// Runs the timeout scenario when FB_WRITER_TIMEOUT_EN is defined, otherwise the indefinite-wait scenario.
module tb_framebuffer_writer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_strobe;
  logic [7:0]  ram_data_out;
  logic [11:0] ram_address;
  logic        ram_clk_enable;
  logic        ram_write_enable;
  logic        busy;
  logic        frame_done;
  logic        error;

  typedef struct {
    bit        fd;
    bit [11:0] a;
    bit [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  err_seen = 0;
  int  exp_err = 0;
  int  fd_seen = 0;
  int  exp_fd = 0;

  framebuffer_writer #(
    .TIMEOUT_WIDTH (16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_strobe       (rx_strobe),
    .ram_data_out    (ram_data_out),
    .ram_address     (ram_address),
    .ram_clk_enable  (ram_clk_enable),
    .ram_write_enable(ram_write_enable),
    .busy            (busy),
    .frame_done      (frame_done),
    .error           (error)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write-port monitor: every write must match the next entry the model queued
  always @(negedge clk_in) begin
    if (ram_clk_enable || ram_write_enable)
      chk("ce_eq_we", ram_clk_enable, ram_write_enable);
    if (ram_write_enable) begin
      chk("wr_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", ram_address, e.a);
        chk("wr_data", ram_data_out, e.d);
        chk("wr_fd", frame_done, e.fd);
      end
    end
    if (frame_done) begin
      fd_seen++;
      chk("fd_with_wr", ram_write_enable, 1);
    end
    if (error) err_seen++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(posedge clk_in);
    #1;
    rx_strobe = 1'b0;
  endtask

  task automatic load_bytes(input int first, input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.a  = 12'(first + i);
      e.d  = rnd ? 8'($urandom) : 8'((first + i) & 8'hFF);
      e.fd = ((first + i) == 4095);
      if (e.fd) exp_fd++;
      exp_q.push_back(e);
      send_byte(e.d);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    wr_t e;
    send_byte(8'h50);
    send_byte({4'h0, a[11:8]});
    send_byte(a[7:0]);
    e.a  = a;
    e.d  = d;
    e.fd = 1'b0;
    exp_q.push_back(e);
    send_byte(d);
    chk("poke_we", ram_write_enable, 1);
    chk("poke_addr", ram_address, a);
    chk("poke_data", ram_data_out, d);
    idle(1);
    chk("poke_single", ram_write_enable, 0);
    chk("poke_idle", busy, 0);
  endtask

  task automatic bad_cmd(input logic [7:0] b);
    exp_err++;
    send_byte(b);
    chk("err_bad_cmd", error, 1);
    chk("err_busy", busy, 0);
  endtask

`ifdef FB_WRITER_TIMEOUT_EN
  task automatic wait_timeout();
    int  n   = 0;
    bit  got = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk_in);
      #1;
      if (error) begin
        n   = i;
        got = 1'b1;
        break;
      end
    end
    exp_err++;
    chk("tmo_seen", got, 1);
    chk("tmo_latency", (n >= 95 && n <= 110), 1);
    chk("tmo_idle", busy, 0);
  endtask
`endif

  initial begin
    logic [7:0] g;
    reset     = 1'b0;
    rx_strobe = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_data", ram_data_out, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_ce", ram_clk_enable, 0);
    chk("rst_we", ram_write_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_err", error, 0);
    reset = 1'b1;
    idle(1);
    chk("busy_after_rst", busy, 0);

    // Full frame with the (i & 0xFF) pattern on back-to-back strobes
    send_byte(8'h4C);
    chk("busy_after_L", busy, 1);
    load_bytes(0, 4096, 1'b0);
    idle(2);
    chk("frame_idle", busy, 0);
    chk("frame_fd_cnt", fd_seen, exp_fd);

    poke(12'h123, 8'hAB);
    for (int i = 0; i < 8; i++) poke(12'($urandom), 8'($urandom));

    bad_cmd(8'h00);
    for (int i = 0; i < 5; i++) begin
      do g = 8'($urandom); while (g == 8'h4C || g == 8'h50);
      bad_cmd(g);
    end
    send_byte(8'h50);
    chk("poke_hi_busy", busy, 1);
    bad_cmd(8'h10);
    send_byte(8'h50);
    bad_cmd({4'($urandom_range(1, 15)), 4'($urandom)});

    // A load accepted after the errors, interrupted by reset after 10 bytes
    send_byte(8'h4C);
    chk("L_after_err", busy, 1);
    load_bytes(0, 10, 1'b1);
    @(negedge clk_in);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_we", ram_write_enable, 0);
    chk("midrst_addr", ram_address, 0);
    rx_data   = 8'h4C;
    rx_strobe = 1'b1;
    idle(3);
    rx_strobe = 1'b0;
    chk("midrst_hold", busy, 0);
    reset = 1'b1;
    idle(2);
    chk("rel_busy", busy, 0);
    chk("rel_no_wr", exp_q.size(), 0);

    send_byte(8'h4C);
    load_bytes(0, 4096, 1'b1);
    idle(2);
    chk("frame2_idle", busy, 0);

`ifdef FB_WRITER_TIMEOUT_EN
    send_byte(8'h4C);
    load_bytes(0, 3, 1'b1);
    wait_timeout();
    send_byte(8'h4C);
    load_bytes(0, 4, 1'b1);
    wait_timeout();
`else
    send_byte(8'h4C);
    load_bytes(0, 3, 1'b1);
    idle(300);
    chk("wait_busy", busy, 1);
    chk("wait_no_err", err_seen, exp_err);
    load_bytes(3, 4093, 1'b1);
    idle(2);
    chk("resume_idle", busy, 0);
`endif

    idle(3);
    chk("end_q_empty", exp_q.size(), 0);
    chk("end_err_cnt", err_seen, exp_err);
    chk("end_fd_cnt", fd_seen, exp_fd);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
